// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared types and default widths for the FIFO drain controller
package fifo_drain_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_LEN_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// rtl/fifo_drain_ctrl_if.sv - FIFO read side and downstream valid/ready stream of the drain controller
interface fifo_drain_ctrl_if
  import fifo_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) ();

  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_underflow;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  fifo_empty, fifo_data_out, fifo_underflow, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data_out, fifo_underflow, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );

endinterface

// File: rtl/drain_skid_buf.sv
// rtl/drain_skid_buf.sv - 2-entry in-order output buffer; entry 0 is always the head
module drain_skid_buf
  import fifo_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [FIFO_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [FIFO_WIDTH-1:0] head
);

  logic [1:0]            occ_q, occ_d;
  logic [FIFO_WIDTH-1:0] ent0_q, ent0_d;
  logic [FIFO_WIDTH-1:0] ent1_q, ent1_d;
  logic                  pop_ok;
  logic                  push_ok;

  assign pop_ok  = pop && (occ_q != 2'd0);
  assign push_ok = push && (occ_q != 2'd2 || pop_ok);

  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) begin
          ent0_d = push_data;
        end else begin
          ent1_d = push_data;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop: shift forward and append, occupancy unchanged.
        if (occ_q == 2'd1) begin
          ent0_d = push_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign occ  = occ_q;
  assign head = ent0_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - drains a burst of len words from a FIFO into a valid/ready stream
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err_underflow,
  fifo_drain_ctrl_if.master bus
);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic                  err_q, err_d;
  logic [1:0]            occ;
  logic [FIFO_WIDTH-1:0] head;
  logic                  pop;
  logic                  rd_en;
  logic [2:0]            occ_after;

  assign pop = (occ != 2'd0) && bus.m_ready;

  // Occupancy the buffer will hold once the pending capture and this cycle's pop settle.
  assign occ_after = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    inflight_d = 1'b0;
    err_d      = err_q;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = len;
          err_d   = 1'b0;
          state_d = (len != '0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        rd_en = !rst && (rem_q != '0) && !bus.fifo_empty && (occ_after < 3'd2);
        if (rd_en) begin
          rem_d      = rem_q - LEN_W'(1);
          inflight_d = 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (!inflight_q && occ == 2'd0) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.fifo_underflow) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  drain_skid_buf #(
    .FIFO_WIDTH(FIFO_WIDTH)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (bus.fifo_data_out),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != 2'd0);
  assign bus.m_data     = head;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign err_underflow  = err_q;

endmodule
